event_sequencer: RTL

EVENT_SEQUENCER -- requirements
Module: event_sequencer

---
 rtl/event_sequencer_pkg.sv | 14 +
 rtl/event_sequencer_sat_counter.sv | 23 ++
 rtl/event_sequencer.sv | 83 ++++++++
 3 files changed

// File: rtl/event_sequencer_pkg.sv
// event_sequencer_pkg: shared state encoding and timer sizing for event_sequencer
package event_sequencer_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FIRE = 2'd3;

    // Timer width is clog2(TIMEOUT), never below one bit so TIMEOUT of 0 or 1 still elaborates.
    function automatic int timer_w(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

// File: rtl/event_sequencer_sat_counter.sv
// sat_counter: saturating up-counter
// Ports: clk, rst (async, active-low), clr (sync clear, overrides en),
//        en (update enable), inc (count request), cnt (current count)
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && inc && cnt != '1)
            cnt <= cnt + W'(1);

endmodule

// File: rtl/event_sequencer.sv
// event_sequencer: IDLE -> ARM -> WAIT -> FIRE event sequencer with WAIT timeout and completion count
// Ports: clk, rst (async, active-low), en (update enable), clr (sync clear),
//        a (event inputs), busy (not FIRE), fire (in FIRE), state_o (state encoding),
//        timeout (one-cycle pulse after WAIT abort), fire_cnt (saturating completed-sequence count)
module event_sequencer
    import event_sequencer_pkg::*;
#(
    parameter int              N_IN       = 4,
    parameter logic [N_IN-1:0] ARM_MASK   = '1,
    parameter logic [N_IN-1:0] FIRE_MASK  = N_IN'(4'b1010),
    parameter int              ARM_STAGES = 1,
    parameter int              TIMEOUT    = 16,
    parameter int              CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [N_IN-1:0]  a,
    output logic             busy,
    output logic             fire,
    output logic [1:0]       state_o,
    output logic             timeout,
    output logic [CNT_W-1:0] fire_cnt
);

    localparam int            TW     = timer_w(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    A_LAST = 4'(ARM_STAGES - 1);

    logic [1:0]    state, nxt;
    logic [3:0]    arm_cnt;
    logic [TW-1:0] timer;
    logic          armq, fireq, expire;

    assign armq    = |(a & ARM_MASK);
    assign fireq   = |(a & FIRE_MASK);
    assign expire  = (TIMEOUT != 0) && (timer == T_LAST);
    assign busy    = state != S_FIRE;
    assign fire    = state == S_FIRE;
    assign state_o = state;

    // fireq is tested before expiry so a qualifying event on the last WAIT cycle still fires.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = armq ? S_ARM : S_IDLE;
            S_ARM:   nxt = (armq && arm_cnt == A_LAST) ? S_WAIT : S_ARM;
            S_WAIT:  nxt = fireq ? S_FIRE : expire ? S_IDLE : S_WAIT;
            default: nxt = fireq ? S_IDLE : S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= S_IDLE;
            arm_cnt <= '0;
            timer   <= '0;
            timeout <= 1'b0;
        end else if (clr) begin
            state   <= S_IDLE;
            arm_cnt <= '0;
            timer   <= '0;
            timeout <= 1'b0;
        end else if (en) begin
            state   <= nxt;
            arm_cnt <= (state == S_IDLE) ? 4'd0 : (state == S_ARM && armq) ? arm_cnt + 4'd1 : arm_cnt;
            timer   <= (nxt == S_WAIT && state != S_WAIT) ? '0 : (state == S_WAIT) ? timer + TW'(1) : timer;
            timeout <= state == S_WAIT && !fireq && expire;
        end else begin
            timeout <= 1'b0;
        end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (en),
        .inc (state == S_FIRE && fireq),
        .cnt (fire_cnt)
    );

endmodule
